// File: rtl/demod_pkg.sv
// rtl/demod_pkg.sv - shared constants, state encoding and reference helpers for segment demodulation
package demod_pkg;

  localparam int N_SEG = 10;
  localparam int W     = 32;
  localparam int IDX_W = 4;

  localparam logic [W-1:0] ONE       = 32'h0001_0000;
  localparam logic [W-1:0] MINUS_ONE = 32'hFFFF_0000;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Even slots expect +1.0, odd slots expect -1.0; ref_m is always the opposite symbol.
  function automatic logic [W-1:0] ref_of(input logic [IDX_W-1:0] idx);
    return idx[0] ? MINUS_ONE : ONE;
  endfunction

  function automatic logic [W-1:0] ref_m_of(input logic [IDX_W-1:0] idx);
    return idx[0] ? ONE : MINUS_ONE;
  endfunction

endpackage

// File: rtl/segment_decider.sv
// rtl/segment_decider.sv - registered nearest-reference decision between ref_val and ref_m
module segment_decider
  import demod_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x,
  input  logic [W-1:0] ref_val,
  input  logic [W-1:0] ref_m,
  output logic [W-1:0] decision
);

  // One extra bit keeps x - ref and its magnitude exact across the full Q16.16 range.
  logic signed [W:0] xs, rp, rm, dp_raw, dm_raw, dp, dm;

  assign xs     = {x[W-1], x};
  assign rp     = {ref_val[W-1], ref_val};
  assign rm     = {ref_m[W-1], ref_m};
  assign dp_raw = xs - rp;
  assign dm_raw = xs - rm;
  assign dp     = dp_raw[W] ? -dp_raw : dp_raw;
  assign dm     = dm_raw[W] ? -dm_raw : dm_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      decision <= '0;
    end else begin
      decision <= (dp <= dm) ? ref_val : ref_m;
    end
  end

endmodule

// File: rtl/demod_segment_scheduler.sv
// rtl/demod_segment_scheduler.sv - collects a frame of samples and time-shares one decider across all slots
module demod_segment_scheduler
  import demod_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] input_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] segment_0,
  output logic [W-1:0] segment_1,
  output logic [W-1:0] segment_2,
  output logic [W-1:0] segment_3,
  output logic [W-1:0] segment_4,
  output logic [W-1:0] segment_5,
  output logic [W-1:0] segment_6,
  output logic [W-1:0] segment_7,
  output logic [W-1:0] segment_8,
  output logic [W-1:0] segment_9,
  output logic         valid,
  output logic         busy
);

  state_t           state;
  logic [IDX_W-1:0] k, i, i_d;
  logic             iss_v;
  logic [W-1:0]     sample [N_SEG];
  logic [W-1:0]     result [N_SEG];
  logic [W-1:0]     seg_q  [N_SEG];
  logic [W-1:0]     dec_x, dec_ref, dec_ref_m, dec_out;

  always_comb begin
    dec_x = '0;
    for (int j = 0; j < N_SEG; j++) begin
      if (i == IDX_W'(j)) dec_x = sample[j];
    end
  end

  assign dec_ref   = ref_of(i);
  assign dec_ref_m = ref_m_of(i);

  segment_decider u_decider (
    .clk      (clk),
    .reset    (reset),
    .x        (dec_x),
    .ref_val  (dec_ref),
    .ref_m    (dec_ref_m),
    .decision (dec_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      i     <= '0;
      i_d   <= '0;
      iss_v <= 1'b0;
      valid <= 1'b0;
      for (int j = 0; j < N_SEG; j++) begin
        sample[j] <= '0;
        result[j] <= '0;
        seg_q[j]  <= '0;
      end
    end else begin
      valid <= 1'b0;
      iss_v <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            k     <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            for (int j = 0; j < N_SEG; j++) begin
              if (k == IDX_W'(j)) sample[j] <= input_bit;
            end
            if (k == IDX_W'(N_SEG - 1)) begin
              state <= RUN;
              i     <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        RUN: begin
          for (int j = 0; j < N_SEG; j++) begin
            if (iss_v && i_d == IDX_W'(j)) result[j] <= dec_out;
          end
          if (i != IDX_W'(N_SEG)) begin
            iss_v <= 1'b1;
            i_d   <= i;
            i     <= i + 1'b1;
          end else begin
            // Drain cycle: the last decision bypasses the result file so valid lands in DONE.
            for (int j = 0; j < N_SEG; j++) begin
              seg_q[j] <= (iss_v && i_d == IDX_W'(j)) ? dec_out : result[j];
            end
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign segment_0 = seg_q[0];
  assign segment_1 = seg_q[1];
  assign segment_2 = seg_q[2];
  assign segment_3 = seg_q[3];
  assign segment_4 = seg_q[4];
  assign segment_5 = seg_q[5];
  assign segment_6 = seg_q[6];
  assign segment_7 = seg_q[7];
  assign segment_8 = seg_q[8];
  assign segment_9 = seg_q[9];

endmodule

// File: tb/tb_demod_segment_scheduler.sv
// tb/tb_demod_segment_scheduler.sv - directed self-checking bench for demod_segment_scheduler
module tb_demod_segment_scheduler;

  typedef logic [31:0] frame_t [10];

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] input_bit;
  logic        in_ready, valid, busy;
  logic [31:0] seg [10];

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;

  always #5 clk = ~clk;

  demod_segment_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .input_bit (input_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .segment_0 (seg[0]),
    .segment_1 (seg[1]),
    .segment_2 (seg[2]),
    .segment_3 (seg[3]),
    .segment_4 (seg[4]),
    .segment_5 (seg[5]),
    .segment_6 (seg[6]),
    .segment_7 (seg[7]),
    .segment_8 (seg[8]),
    .segment_9 (seg[9]),
    .valid     (valid),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle with start high; returns relative cycle of valid and of the first idle cycle.
  task automatic run_frame(input frame_t s, input bit bubbles, input bit poke,
                           output int vcyc, output int vcnt, output int bend, output int moved);
    int     k;
    frame_t pre;
    k = 0; vcyc = -1; vcnt = 0; bend = -1; moved = 0;
    for (int j = 0; j < 10; j++) pre[j] = seg[j];
    for (int c = 0; c < 80 && bend < 0; c++) begin
      start     = (c == 0) || (poke && (c == 4 || c == 14 || c == 22));
      in_valid  = (k < 10) && (!bubbles || (c % 2 == 0));
      input_bit = (k < 10) ? s[k] : 32'hDEAD_BEEF;
      if (valid) begin
        vcnt++;
        vcyc = c;
      end
      if (c >= 1 && !busy) bend = c;
      if (vcnt == 0) begin
        for (int j = 0; j < 10; j++) if (seg[j] !== pre[j]) moved++;
      end
      if (in_valid && in_ready) k++;
      if (bend < 0) step();
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  frame_t alt, ext, exp_alt, exp_ext;
  int vcyc, vcnt, bend, moved, k, vseen, busy15, g0, g1, vcyc_a;

  initial begin
    alt     = '{32'h0000_8000, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_8000, 32'h0000_8000,
                32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_8000};
    exp_alt = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000,
                32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000};
    ext     = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_0000,
                32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0002_0000, 32'hFFFE_0000};
    exp_ext = '{32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; input_bit = '0;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    for (int j = 0; j < 10; j++) check($sformatf("rst_seg%0d", j), seg[j], 32'h0);
    reset = 1'b0;
    step();

    run_frame(alt, 1'b0, 1'b0, vcyc, vcnt, bend, moved);
    check("alt_valid_cycle", 32'(vcyc), 32'd22);
    check("alt_valid_count", 32'(vcnt), 32'd1);
    check("alt_busy_end", 32'(bend), 32'd23);
    check("alt_seg_stable", 32'(moved), 32'd0);
    for (int j = 0; j < 10; j++) check($sformatf("alt_seg%0d", j), seg[j], exp_alt[j]);

    run_frame(ext, 1'b0, 1'b0, vcyc, vcnt, bend, moved);
    check("ext_valid_cycle", 32'(vcyc), 32'd22);
    for (int j = 0; j < 10; j++) check($sformatf("ext_seg%0d", j), seg[j], exp_ext[j]);

    run_frame(alt, 1'b1, 1'b0, vcyc, vcnt, bend, moved);
    check("bub_valid_cycle", 32'(vcyc), 32'd32);
    check("bub_busy_end", 32'(bend), 32'd33);
    for (int j = 0; j < 10; j++) check($sformatf("bub_seg%0d", j), seg[j], exp_alt[j]);

    run_frame(ext, 1'b0, 1'b1, vcyc, vcnt, bend, moved);
    check("poke_valid_count", 32'(vcnt), 32'd1);
    check("poke_valid_cycle", 32'(vcyc), 32'd22);
    check("poke_busy_end", 32'(bend), 32'd23);
    check("poke_seg_stable", 32'(moved), 32'd0);
    for (int j = 0; j < 10; j++) check($sformatf("poke_seg%0d", j), seg[j], exp_ext[j]);

    k = 0; vseen = 0; busy15 = 0;
    for (int c = 0; c <= 15; c++) begin
      start     = (c == 0);
      in_valid  = (k < 10);
      input_bit = (k < 10) ? alt[k] : 32'h0;
      if (valid) vseen++;
      if (c == 15) begin
        busy15 = 32'(busy);
        reset  = 1'b1;
      end
      if (in_valid && in_ready) k++;
      step();
    end
    if (valid) vseen++;
    check("mid_busy_before", 32'(busy15), 32'd1);
    check("mid_busy_after", 32'(busy), 32'd0);
    check("mid_in_ready_after", 32'(in_ready), 32'd0);
    check("mid_no_valid", 32'(vseen), 32'd0);
    for (int j = 0; j < 10; j++) check($sformatf("mid_seg%0d", j), seg[j], 32'h0);
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();

    g0 = gcyc;
    run_frame(alt, 1'b0, 1'b0, vcyc, vcnt, bend, moved);
    vcyc_a = vcyc;
    check("b2b_a_valid_cycle", 32'(vcyc), 32'd22);
    for (int j = 0; j < 10; j++) check($sformatf("b2b_a_seg%0d", j), seg[j], exp_alt[j]);
    g1 = gcyc;
    run_frame(ext, 1'b0, 1'b0, vcyc, vcnt, bend, moved);
    check("b2b_b_valid_count", 32'(vcnt), 32'd1);
    check("b2b_gap", 32'((g1 + vcyc) - (g0 + vcyc_a)), 32'd23);
    for (int j = 0; j < 10; j++) check($sformatf("b2b_b_seg%0d", j), seg[j], exp_ext[j]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
